// File: rtl/ay5876_d_flip_flop.sv
// rtl/ay5876_d_flip_flop.sv - 8-bit mode-selectable D register with zero/parity/change flags
module ay5876_d_flip_flop (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0] mode;
  logic       ce;
  logic       clr;
  logic       set;
  logic [7:0] q;
  logic [7:0] next_q;
  logic       chg;
  logic       unused_uio;

  assign mode       = uio_in[1:0];
  assign ce         = uio_in[2];
  assign clr        = uio_in[3];
  assign set        = uio_in[4];
  assign unused_uio = &{1'b0, uio_in[7:5]};

  // clr beats set, and both override ce and mode
  always_comb begin
    next_q = q;
    if (clr) begin
      next_q = 8'h00;
    end else if (set) begin
      next_q = 8'hFF;
    end else if (ce) begin
      case (mode)
        2'b00:   next_q = ui_in;
        2'b01:   next_q = q ^ ui_in;
        2'b10:   next_q = q | ui_in;
        default: next_q = q & ~ui_in;
      endcase
    end
  end

  // rst_n is active-high here; the name is inherited from the wider codebase
  always_ff @(posedge clk) begin
    if (rst_n) begin
      q   <= 8'h00;
      chg <= 1'b0;
    end else if (ena) begin
      q   <= next_q;
      chg <= (next_q != q);
    end
  end

  assign uo_out  = q;
  assign uio_out = {(q == 8'h00), ^q, chg, 5'b00000};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_ay5876_d_flip_flop.sv
// tb/tb_ay5876_d_flip_flop.sv - directed self-checking bench for ay5876_d_flip_flop
module tb_ay5876_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  ay5876_d_flip_flop dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [7:0] u);
    rst_n  = r;
    ena    = e;
    ui_in  = d;
    uio_in = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;

    // reset held two edges, with ena low and set requested
    step(1'b1, 1'b0, 8'h00, 8'h10);
    step(1'b1, 1'b1, 8'h5A, 8'h14);
    check("rst_q",   uo_out,  8'h00);
    check("rst_flg", uio_out, 8'h80);
    check("rst_oe",  uio_oe,  8'hE0);

    // load, then identical load
    step(1'b0, 1'b1, 8'hA5, 8'h04);
    check("load_q",    uo_out,  8'hA5);
    check("load_flg",  uio_out, 8'h20);
    step(1'b0, 1'b1, 8'hA5, 8'h04);
    check("reload_q",   uo_out,  8'hA5);
    check("reload_flg", uio_out, 8'h00);

    // toggle twice, OR-mask, AND-NOT mask
    step(1'b0, 1'b1, 8'h0F, 8'h05);
    check("tog1_q", uo_out, 8'hAA);
    step(1'b0, 1'b1, 8'h0F, 8'h05);
    check("tog2_q", uo_out, 8'hA5);
    step(1'b0, 1'b1, 8'h50, 8'h06);
    check("or_q",   uo_out, 8'hF5);
    step(1'b0, 1'b1, 8'hF0, 8'h07);
    check("andn_q",   uo_out,  8'h05);
    check("andn_flg", uio_out, 8'h20);

    // toggle with empty mask is a no-change op
    step(1'b0, 1'b1, 8'h00, 8'h05);
    check("tog0_q",   uo_out,  8'h05);
    check("tog0_flg", uio_out, 8'h00);

    // odd parity value
    step(1'b0, 1'b1, 8'h07, 8'h04);
    check("par_q",   uo_out,  8'h07);
    check("par_flg", uio_out, 8'h60);

    // clr wins over set, then set alone
    step(1'b0, 1'b1, 8'h3C, 8'h18);
    check("clrset_q",   uo_out,  8'h00);
    check("clrset_flg", uio_out, 8'hA0);
    step(1'b0, 1'b1, 8'h00, 8'h10);
    check("set_q",   uo_out,  8'hFF);
    check("set_flg", uio_out, 8'h20);

    // ena low: Q and chg hold
    step(1'b0, 1'b0, 8'h3C, 8'h04);
    check("hold_q",   uo_out,  8'hFF);
    check("hold_flg", uio_out, 8'h20);

    // ce low: Q holds, chg clears
    step(1'b0, 1'b1, 8'h3C, 8'h00);
    check("ce0_q",   uo_out,  8'hFF);
    check("ce0_flg", uio_out, 8'h00);

    // reset overrides a toggle on the same edge
    step(1'b0, 1'b1, 8'h0F, 8'h05);
    check("pretog_q", uo_out, 8'hF0);
    step(1'b1, 1'b1, 8'h0F, 8'h05);
    check("midrst_q",   uo_out,  8'h00);
    check("midrst_flg", uio_out, 8'h80);
    step(1'b0, 1'b1, 8'h01, 8'h04);
    check("resume_q",   uo_out,  8'h01);
    check("resume_flg", uio_out, 8'h60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
